// File: rtl/pb_irq_arbiter.sv
// Round-robin interrupt arbiter and cause/pending/overrun register block for the PicoBlaze I/O bus.
// Optional ack timeout is enabled by defining IRQ_TIMEOUT_EN.
module pb_irq_arbiter #(
    parameter int          NUM_SRC        = 4,
    parameter logic [7:0]  CAUSE_PORT     = 8'h25,
    parameter logic [7:0]  PEND_PORT      = 8'h26,
    parameter logic [7:0]  OVR_PORT       = 8'h27,
    parameter logic [7:0]  MASK_PORT      = 8'h35,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic               sysclk,
    input  logic               sysreset,
    input  logic [NUM_SRC-1:0] src_req,
    input  logic [7:0]         port_id,
    input  logic [7:0]         out_port,
    input  logic               writestrobe,
    input  logic               readstrobe,
    input  logic               interrupt_ack,
    output logic               interrupt,
    output logic [7:0]         rd_data,
    output logic               irq_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_HOLDOFF
    } state_t;

    state_t state, state_next;

    logic [NUM_SRC-1:0] pending, mask, overrun;
    logic [NUM_SRC-1:0] eligible, pick_vec, clr_vec, gid_vec, retry_vec;
    logic [NUM_SRC-1:0] ovr_new, ovr_kept;
    logic [2:0]         grant_id, rr_ptr, rr_pick;
    logic [3:0]         rr_idx;
    logic [7:0]         elig8;
    logic               rr_found;
    logic               cause_valid, timeout_flag, hold_cnt;
    logic               grant_fire, timeout_fire;
    logic               cause_rd, mask_wr, ovr_wr;
    logic               unused_bits;

    assign eligible   = pending & mask;
    assign grant_fire = (state == S_IDLE) && (|eligible);
    assign cause_rd   = readstrobe  && (port_id == CAUSE_PORT);
    assign mask_wr    = writestrobe && (port_id == MASK_PORT);
    assign ovr_wr     = writestrobe && (port_id == OVR_PORT);
    assign unused_bits = ^out_port;

    // Rotating search: first eligible source after the last one granted.
    always_comb begin
        elig8    = 8'(eligible);
        rr_found = 1'b0;
        rr_pick  = rr_ptr;
        rr_idx   = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            rr_idx = {1'b0, rr_ptr} + 4'(i);
            if (rr_idx >= 4'(NUM_SRC)) rr_idx = rr_idx - 4'(NUM_SRC);
            if (!rr_found && elig8[rr_idx[2:0]]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx[2:0];
            end
        end
    end

    assign pick_vec  = NUM_SRC'(8'd1 << rr_pick);
    assign gid_vec   = NUM_SRC'(8'd1 << grant_id);
    assign clr_vec   = grant_fire   ? pick_vec : '0;
    assign retry_vec = timeout_fire ? gid_vec  : '0;

    // A request landing on a bit the grant is clearing re-sets it and is not an overrun.
    assign ovr_new  = src_req & pending & ~clr_vec;
    assign ovr_kept = ovr_wr ? (overrun & ~out_port[NUM_SRC-1:0]) : overrun;

`ifdef IRQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] to_cnt;

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset)                to_cnt <= '0;
        else if (grant_fire)         to_cnt <= '0;
        else if (state == S_ASSERT)  to_cnt <= to_cnt + CW'(1);
    end

    assign timeout_fire = (state == S_ASSERT) && !interrupt_ack &&
                          (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_cfg;
    assign timeout_fire = 1'b0;
    assign unused_cfg   = (TIMEOUT_CYCLES == 0);
`endif

    // NOTE: state and registers use non-blocking assignments only; comb blocks default every output first so no latches form.
    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:    if (grant_fire) state_next = S_ASSERT;
            S_ASSERT:  if (interrupt_ack || timeout_fire) state_next = S_HOLDOFF;
            S_HOLDOFF: if (hold_cnt) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        interrupt = (state == S_ASSERT);
        irq_busy  = (state != S_IDLE);
    end

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            pending      <= '0;
            overrun      <= '0;
            mask         <= '1;
            grant_id     <= '0;
            rr_ptr       <= 3'(NUM_SRC - 1);
            cause_valid  <= 1'b0;
            timeout_flag <= 1'b0;
            hold_cnt     <= 1'b0;
        end else begin
            pending  <= (pending & ~clr_vec) | src_req | retry_vec;
            overrun  <= ovr_kept | ovr_new;
            hold_cnt <= (state == S_HOLDOFF) && !hold_cnt;
            if (mask_wr) mask <= out_port[NUM_SRC-1:0];
            if (grant_fire) begin
                grant_id <= rr_pick;
                rr_ptr   <= rr_pick;
            end
            if (grant_fire)    cause_valid <= 1'b1;
            else if (cause_rd) cause_valid <= 1'b0;
            if (timeout_fire)  timeout_flag <= 1'b1;
            else if (cause_rd) timeout_flag <= 1'b0;
        end
    end

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            rd_data <= 8'h00;
        end else begin
            case (port_id)
                CAUSE_PORT: rd_data <= {cause_valid, timeout_flag, 3'b000, grant_id};
                PEND_PORT:  rd_data <= 8'(pending);
                OVR_PORT:   rd_data <= 8'(overrun);
                default:    rd_data <= 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_pb_irq_arbiter.sv
// Scoreboard bench for pb_irq_arbiter: stimulus queues expected read bytes and interrupt edges,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_pb_irq_arbiter;

    localparam int NUM_SRC = 4;
    localparam logic [7:0] CAUSE = 8'h25, PEND = 8'h26, OVR = 8'h27, MASK = 8'h35;

    logic               sysclk = 1'b0;
    logic               sysreset;
    logic [NUM_SRC-1:0] src_req;
    logic [7:0]         port_id, out_port;
    logic               writestrobe, readstrobe, interrupt_ack;
    logic               interrupt, irq_busy;
    logic [7:0]         rd_data;

    pb_irq_arbiter #(.NUM_SRC(NUM_SRC), .TIMEOUT_CYCLES(16)) dut (
        .sysclk(sysclk), .sysreset(sysreset), .src_req(src_req),
        .port_id(port_id), .out_port(out_port), .writestrobe(writestrobe),
        .readstrobe(readstrobe), .interrupt_ack(interrupt_ack),
        .interrupt(interrupt), .rd_data(rd_data), .irq_busy(irq_busy)
    );

    always #5 sysclk = ~sysclk;

    typedef struct { logic [7:0] value; string name; } rd_exp_t;
    typedef struct { logic lvl; int cyc; } irq_exp_t;

    rd_exp_t  exp_rd[$];
    irq_exp_t exp_irq[$];
    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    logic irq_prev = 1'b0;

    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected DUT event (cycle %0d)", name, cyc);
    endtask

    // Monitor: read data while readstrobe is high, and every interrupt transition.
    always @(negedge sysclk) begin
        rd_exp_t  r;
        irq_exp_t e;
        if (readstrobe) begin
            if (exp_rd.size() == 0) fail_now("read_unexpected");
            else begin
                r = exp_rd.pop_front();
                check(r.name, 32'(rd_data), 32'(r.value));
            end
        end
        if (interrupt !== irq_prev) begin
            if (exp_irq.size() == 0) fail_now("irq_edge_unexpected");
            else begin
                e = exp_irq.pop_front();
                check("irq_edge_level", 32'(interrupt), 32'(e.lvl));
                check("irq_edge_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        irq_prev = interrupt;
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic exp_edge(input logic lvl, input int at);
        irq_exp_t e;
        e.lvl = lvl;
        e.cyc = at;
        exp_irq.push_back(e);
    endtask

    task automatic pulse(input logic [NUM_SRC-1:0] req);
        src_req = req;
        tick();
        src_req = '0;
    endtask

    task automatic rd(input logic [7:0] port, input logic [7:0] value, input string name);
        rd_exp_t r;
        r.value = value;
        r.name  = name;
        port_id = port;
        tick();
        exp_rd.push_back(r);
        readstrobe = 1'b1;
        tick();
        readstrobe = 1'b0;
        port_id    = 8'h00;
    endtask

    task automatic wr(input logic [7:0] port, input logic [7:0] data);
        port_id     = port;
        out_port    = data;
        writestrobe = 1'b1;
        tick();
        writestrobe = 1'b0;
        port_id     = 8'h00;
        out_port    = 8'h00;
    endtask

    // Ack in cycle M: interrupt falls at edge M+1; a waiting request re-asserts at M+4.
    task automatic ack(input bit more);
        exp_edge(1'b0, cyc + 1);
        if (more) exp_edge(1'b1, cyc + 4);
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
    endtask

    task automatic wait_irq(input string name);
        for (int i = 0; i < 40 && !interrupt; i++) tick();
        check(name, 32'(interrupt), 32'd1);
    endtask

    task automatic reset_dut();
        sysreset = 1'b1;
        tick();
        sysreset = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sysreset = 1'b1;
        src_req = '0; port_id = 8'h00; out_port = 8'h00;
        writestrobe = 1'b0; readstrobe = 1'b0; interrupt_ack = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
        sysreset = 1'b0;
        tick();

        // Reset state
        check("reset_interrupt", 32'(interrupt), 32'd0);
        check("reset_busy", 32'(irq_busy), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'd0);
        rd(PEND, 8'h00, "reset_pend");
        rd(OVR, 8'h00, "reset_ovr");
        rd(CAUSE, 8'h00, "reset_cause");

        // Single event on source 2
        exp_edge(1'b1, cyc + 2);
        pulse(4'b0100);
        tick();
        tick();
        check("single_busy", 32'(irq_busy), 32'd1);
        rd(CAUSE, 8'h82, "single_cause");
        rd(PEND, 8'h00, "single_pend_cleared");
        ack(1'b0);
        repeat (3) tick();
        check("single_idle", 32'(irq_busy), 32'd0);
        rd(CAUSE, 8'h02, "single_cause_after_read");

        // Round-robin from a fresh pointer: 0,1,2,3
        reset_dut();
        exp_edge(1'b1, cyc + 2);
        pulse(4'b1111);
        for (int k = 0; k < 4; k++) begin
            wait_irq("rr_irq_seen");
            rd(CAUSE, 8'h80 | 8'(k), "rr_cause");
            if (k == 0) rd(PEND, 8'h0E, "rr_pend_after_first");
            ack(k < 3);
        end
        repeat (3) tick();

        // Mask: source 0 latches but is not granted until unmasked
        wr(MASK, 8'h0E);
        pulse(4'b0001);
        repeat (4) tick();
        check("mask_no_irq", 32'(interrupt), 32'd0);
        rd(PEND, 8'h01, "mask_pend");
        exp_edge(1'b1, cyc + 2);
        wr(MASK, 8'h0F);
        wait_irq("mask_unmask_irq");
        rd(CAUSE, 8'h80, "mask_cause");
        ack(1'b0);
        repeat (3) tick();

        // Overrun on masked source 1, then W1C
        wr(MASK, 8'h0D);
        pulse(4'b0010);
        pulse(4'b0010);
        rd(OVR, 8'h02, "ovr_set");
        rd(PEND, 8'h02, "ovr_pend");
        wr(OVR, 8'h02);
        rd(OVR, 8'h00, "ovr_cleared");

        // Request coinciding with its own grant: pending survives, no overrun
        exp_edge(1'b1, cyc + 2);
        wr(MASK, 8'h0F);
        pulse(4'b0010);
        wait_irq("setwin_irq");
        rd(PEND, 8'h02, "setwin_pend");
        rd(OVR, 8'h00, "setwin_no_ovr");
        rd(CAUSE, 8'h81, "setwin_cause");
        ack(1'b1);
        wait_irq("setwin_regrant");
        rd(CAUSE, 8'h81, "setwin_cause2");
        ack(1'b0);
        repeat (3) tick();

`ifdef IRQ_TIMEOUT_EN
        // Timeout: no ack for 16 cycles, source 3 re-granted with timeout flag
        reset_dut();
        exp_edge(1'b1, cyc + 2);
        exp_edge(1'b0, cyc + 18);
        exp_edge(1'b1, cyc + 21);
        pulse(4'b1000);
        repeat (20) tick();
        rd(CAUSE, 8'hC3, "timeout_cause");
        ack(1'b0);
        repeat (3) tick();
`endif

        // Reset while ASSERT with another source pending
        exp_edge(1'b1, cyc + 2);
        pulse(4'b0001);
        pulse(4'b0100);
        wait_irq("rst_irq_up");
        tick();
        exp_edge(1'b0, cyc);
        sysreset = 1'b1;
        #1;
        check("rst_irq_immediate", 32'(interrupt), 32'd0);
        check("rst_busy_immediate", 32'(irq_busy), 32'd0);
        tick();
        sysreset = 1'b0;
        rd(PEND, 8'h00, "rst_pend_lost");
        rd(OVR, 8'h00, "rst_ovr");
        rd(CAUSE, 8'h00, "rst_cause");
        repeat (4) tick();
        check("rst_no_irq", 32'(interrupt), 32'd0);

        check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
        check("irq_queue_drained", 32'(exp_irq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pb_irq_arbiter.md
# pb_irq_arbiter

Interrupt arbiter and cause-register controller for the PicoBlaze I/O interface on the Nexys4 bot board. It collects single-cycle event requests from up to 8 sources: system-register update, game tick, accelerometer sample, arrow landing, and spares. It latches them as pending, grants one at a time round-robin, and drives the single PicoBlaze `interrupt`/`interrupt_ack` pair. The ISR reads the granted source ID, the pending vector and the overrun flags through read ports. The top level ORs this block's `rd_data` into `in_port`.

## Interface
- `NUM_SRC`, 4: number of request sources, legal 1..8.
- `CAUSE_PORT`, 8'h25: read port for the cause byte.
- `PEND_PORT`, 8'h26: read port for the pending vector.
- `OVR_PORT`, 8'h27: read port for overrun flags; a write to this port clears them (write-1-to-clear).
- `MASK_PORT`, 8'h35: write port for the enable mask.
- `TIMEOUT_CYCLES`, 1024: ack timeout; used only with `IRQ_TIMEOUT_EN`.

Ports:
- `sysclk` in 1: system clock; all logic on the rising edge.
- `sysreset` in 1: asynchronous, active-high reset.
- `src_req` in NUM_SRC: event pulses; one cycle per event.
- `port_id` in 8: PicoBlaze port address.
- `out_port` in 8: PicoBlaze write data.
- `writestrobe` in 1: PicoBlaze write strobe.
- `readstrobe` in 1: PicoBlaze read strobe.
- `interrupt_ack` in 1: PicoBlaze interrupt acknowledge.
- `interrupt` out 1: interrupt to PicoBlaze.
- `rd_data` out 8: registered read data; 0 when `port_id` matches none of this block's ports.
- `irq_busy` out 1: FSM is not in IDLE.

## Operation
- Registers:
  - `pending[NUM_SRC]`.
  - `mask[NUM_SRC]`, reset all ones.
  - `overrun[NUM_SRC]`.
  - `grant_id[2:0]`.
  - `cause_valid`.
  - `timeout_flag`.
  - `rr_ptr[2:0]`: index of the last granted source.
- Pending capture: `src_req[i]`=1 sets `pending[i]`. If `pending[i]` is already 1 and is not being cleared by a grant that cycle, also set `overrun[i]`.
- Masking: masked sources still latch `pending` but are never granted. Eligible vector = `pending & mask`.
- Round-robin search starts at `rr_ptr+1` and wraps modulo NUM_SRC. Lowest index wins after the rotation.
- FSM states:
  - IDLE: if the eligible vector is nonzero, capture `grant_id`, clear `pending[grant_id]`, set `rr_ptr`=`grant_id`, set `cause_valid`, assert `interrupt`, and go to ASSERT.
  - ASSERT: `interrupt`=1. On `interrupt_ack`, clear `interrupt` and go to HOLDOFF.
  - HOLDOFF: hold 2 cycles with `interrupt`=0, then go to IDLE.
- Cause byte = {`cause_valid`, `timeout_flag`, 3'b0, `grant_id`}.
- A `readstrobe` with `port_id`==`CAUSE_PORT` clears `cause_valid` and `timeout_flag` on the next edge. `grant_id` is retained.
- `PEND_PORT` returns `pending`, zero-extended to 8 bits. `OVR_PORT` returns `overrun`, zero-extended to 8 bits.
- Writes:
  - `writestrobe` with `port_id`==`MASK_PORT`: `mask` <= `out_port[NUM_SRC-1:0]`.
  - `writestrobe` with `port_id`==`OVR_PORT`: `overrun` <= `overrun & ~out_port`.
- Simultaneous events:
  - Set wins over grant-clear on the same bit: pending stays 1 and no overrun is flagged.
  - `interrupt_ack` outside ASSERT is ignored.
  - An overrun write-clear and a new overrun on the same bit in the same cycle leave the bit set.

## Timing
- Reset values:
  - `interrupt`=0, `rd_data`=0, `irq_busy`=0.
  - `pending`, `overrun`, `grant_id`, `rr_ptr`=NUM_SRC-1, `cause_valid`, `timeout_flag` all 0.
  - `mask`=all ones. FSM in IDLE.
- Request to interrupt latency, with the FSM idle: `src_req` high in cycle N -> `pending` set at edge N+1 -> `interrupt` high from edge N+2.
- `interrupt_ack` sampled high in cycle M -> `interrupt` low from edge M+1. The next assertion comes no earlier than edge M+3.
- `rd_data` updates one edge after `port_id` changes, matching PicoBlaze 2-cycle input timing.
- Reset asserted mid-operation returns every register to its reset value immediately. Events that were pending are lost.

## Configuration
- `IRQ_TIMEOUT_EN` defined:
  - A counter runs while in ASSERT.
  - After `TIMEOUT_CYCLES` cycles without `interrupt_ack`: drop `interrupt`, re-set `pending[grant_id]`, set `timeout_flag`, and go to HOLDOFF.
  - The counter clears on entering ASSERT.
- `IRQ_TIMEOUT_EN` undefined: ASSERT waits indefinitely, and `timeout_flag` is constant 0.

## Test plan
- Single event, NUM_SRC=4: `src_req`=4'b0100 pulse at cycle 10 -> `interrupt` high at edge 12; CAUSE read = 8'h82; ack -> `interrupt` low the next edge.
- Round-robin: `src_req`=4'b1111 in one cycle -> grants in order 0,1,2,3 across four ack cycles, with `interrupt` low for ≥2 cycles between grants.
- Mask: write 8'h0E to 8'h35, pulse source 0 -> no interrupt; PEND read = 8'h01; write 8'h0F -> `interrupt` asserts.
- Overrun: two pulses on source 1 while masked -> OVR read = 8'h02; write 8'h02 to OVR_PORT -> OVR read = 8'h00.
- Timeout (IRQ_TIMEOUT_EN, TIMEOUT_CYCLES=16): grant source 3 with no ack -> `interrupt` drops after 16 cycles; re-grant of source 3 with CAUSE read = 8'hC3.
- Reset mid-ASSERT: pulse `sysreset` -> `interrupt`=0 immediately; PEND read = 8'h00.
